// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and width helpers for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO write-side bundle; fifo_tag present under FIFO_ARB_TAG_EN
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int num_req    = 4,
  parameter int data_width = 8
);
  logic [num_req-1:0]            req_valid;
  logic [num_req*data_width-1:0] req_data;
  logic [num_req-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_ena;
  logic [data_width-1:0]         fifo_data_in;
  logic [num_req-1:0]            grant;
  logic                          busy;

`ifdef FIFO_ARB_TAG_EN
  localparam int tag_width = idx_width(num_req);
  logic [tag_width-1:0]          fifo_tag;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_ena, fifo_data_in, grant, busy, fifo_tag
  );
  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_ena, fifo_data_in, grant, busy, fifo_tag
  );
`else
  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_ena, fifo_data_in, grant, busy
  );
  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_ena, fifo_data_in, grant, busy
  );
`endif

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational circular priority picker with exclude mask
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int num_req = 4,
  localparam int IW     = idx_width(num_req)
) (
  input  logic [num_req-1:0] req_i,
  input  logic [IW-1:0]      start_i,
  input  logic [num_req-1:0] excl_i,
  output logic [num_req-1:0] pick_o,
  output logic               any_o
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < num_req; k++) begin
      idx = IW'((int'(start_i) + k) % num_req);
      if (!found && req_i[idx] && !excl_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin bounded-burst arbiter for a FIFO write port; FIFO_ARB_TAG_EN adds fifo_tag
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int num_req    = 4,
  parameter int data_width = 8,
  parameter int max_burst  = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int IW = idx_width(num_req);
  localparam int CW = cnt_width(max_burst);

  arb_state_e            state_q;
  logic [num_req-1:0]    grant_q;
  logic [IW-1:0]         rr_ptr_q;
  logic [CW-1:0]         burst_cnt_q;
  logic                  busy_q;
  logic [data_width-1:0] data_q;

  logic [IW-1:0]         owner_idx;
  logic [data_width-1:0] owner_data;
  logic                  owner_valid;
  logic                  wr_ena;
  logic                  release_now;
  logic [IW-1:0]         next_ptr;
  logic [IW-1:0]         pick_start;
  logic [num_req-1:0]    pick_excl;
  logic [num_req-1:0]    pick;
  logic                  pick_any;

  always_comb begin
    owner_idx  = '0;
    owner_data = '0;
    for (int i = 0; i < num_req; i++) begin
      if (grant_q[i]) begin
        owner_idx  = IW'(i);
        owner_data = bus.req_data[i*data_width +: data_width];
      end
    end
  end

  assign owner_valid = |(grant_q & bus.req_valid);
  assign wr_ena      = (state_q == GRANT) & owner_valid & ~bus.fifo_full & ~rst;
  assign release_now = (state_q == GRANT) &
                       (~owner_valid | (wr_ena & (burst_cnt_q == CW'(max_burst - 1))));
  assign next_ptr    = (owner_idx == IW'(num_req - 1)) ? '0 : owner_idx + 1'b1;

  // One picker serves both paths: fresh pick from rr_ptr in IDLE, hand-off excluding the owner on release.
  assign pick_start  = (state_q == GRANT) ? next_ptr : rr_ptr_q;
  assign pick_excl   = (state_q == GRANT) ? grant_q  : '0;

  rr_pick #(.num_req(num_req)) u_pick (
    .req_i   (bus.req_valid),
    .start_i (pick_start),
    .excl_i  (pick_excl),
    .pick_o  (pick),
    .any_o   (pick_any)
  );

  assign bus.req_ready    = rst ? '0 : (grant_q & {num_req{~bus.fifo_full}});
  assign bus.fifo_wr_ena  = wr_ena;
  assign bus.fifo_data_in = wr_ena ? owner_data : data_q;
  assign bus.grant        = grant_q;
  assign bus.busy         = busy_q;

`ifdef FIFO_ARB_TAG_EN
  logic [IW-1:0] tag_q;
  assign bus.fifo_tag = wr_ena ? owner_idx : tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else if (wr_ena) begin
      tag_q <= owner_idx;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      if (wr_ena) begin
        data_q <= owner_data;
      end
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            rr_ptr_q    <= next_ptr;
            burst_cnt_q <= '0;
            if (pick_any) begin
              grant_q <= pick;
            end else begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (wr_ena) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the synchronous FIFO (depth 8, data width 8) between num_req producers.
- Round-robin arbitration with bounded bursts: a granted producer may write up to max_burst consecutive beats before the grant rotates.
- Sits directly in front of the FIFO: drives its wr_ena and data_in, and consumes its full flag.
- The read side of the FIFO is untouched.

Parameters:
- num_req, 4, number of producers (2..8).
- data_width, 8, beat width; must match the FIFO data width.
- max_burst, 4, maximum beats per grant (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  num_req  per-producer beat valid
- req_data  input  num_req*data_width  packed producer data; slice i = producer i
- req_ready  output  num_req  per-producer accept; beat transfers when valid&ready
- fifo_full  input  1  FIFO full flag
- fifo_wr_ena  output  1  FIFO write enable
- fifo_data_in  output  data_width  FIFO write data
- grant  output  num_req  one-hot current owner, all-zero when idle
- busy  output  1  high while a grant is held

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset state:
  - state=IDLE, grant=0, rr_ptr=0, burst_cnt=0.
  - req_ready=0, fifo_wr_ena=0, fifo_data_in=0, busy=0.
  - fifo_wr_ena is forced low in any cycle where rst=1.
- State machine: IDLE, GRANT.
- IDLE:
  - If any req_valid, pick the first valid index at or after rr_ptr (circular search).
  - Load grant and go to GRANT at the next edge.
  - Cost is one cycle of grant latency; no beat is accepted in IDLE.
- GRANT, owner index g:
  - req_ready[g] = ~fifo_full; all other req_ready = 0.
  - Combinational outputs: fifo_wr_ena = req_valid[g] & ~fifo_full, fifo_data_in = req_data slice g.
  - When fifo_wr_ena=0, fifo_data_in holds its last written value (registered mux output).
- Beat accepted: burst_cnt increments.
- Release happens on either condition:
  - a beat is accepted with burst_cnt==max_burst-1;
  - req_valid[g]=0 in a cycle (voluntary drop, no beat).
- On release:
  - rr_ptr = (g+1) mod num_req and burst_cnt = 0.
  - If another request is pending (using the updated rr_ptr and excluding g), grant moves directly to that requester at the same edge, with no IDLE bubble.
  - Otherwise the block returns to IDLE.
  - g may be re-granted only if it is the only valid requester.
- fifo_full while granted:
  - The grant is held and burst_cnt is frozen.
  - The stall never counts toward max_burst, and the grant is not revoked.
- Burst limit: max_burst=1 gives pure per-beat round-robin.
- Fairness: with all requesters continuously valid, each is served max_burst beats in index order 0,1,…,num_req-1,0…
- Reset mid-burst: the grant is dropped at the reset edge, no write occurs in the reset cycle, and rr_ptr returns to 0.
- burst_cnt width is $clog2(max_burst)+1; rr_ptr width is $clog2(num_req).

Optional Feature:
- Macro: FIFO_ARB_TAG_EN.
- When defined:
  - Adds output fifo_tag [$clog2(num_req)-1:0], equal to the grant index whenever fifo_wr_ena=1 (otherwise it holds).
  - Adds internal parameter tag_width; downstream stores the tag alongside data to demux reads.
- When undefined:
  - The port and its logic are absent.
  - Behaviour is otherwise identical.

Decomposition:
- Package fifo_arb_pkg:
  - state enum arb_state_e {IDLE, GRANT};
  - localparam helpers for index width and count width.
- Sub-module rr_pick: purely combinational circular priority picker.
  - Inputs: req vector, start pointer, exclude mask.
  - Outputs: one-hot pick and any flag.
  - Instantiated once and shared by the IDLE and release paths.

Test Plan:
- Reset: assert rst with req_valid=4'b1111 → grant=0, fifo_wr_ena=0, req_ready=0 throughout; after release, grant=4'b0001 one cycle later.
- Full rotation: all four valid continuously, data=8'h10+i, max_burst=4 → FIFO receives 4×8'h10, 4×8'h11, 4×8'h12, 4×8'h13, then 8'h10 again; no bubble between owners.
- Voluntary drop: only req1 valid for 2 beats then deasserted → 2 writes, grant returns to 0 next edge, busy=0, rr_ptr=2; a subsequent req1 alone gets grant=4'b0010.
- Full stall: owner req2 mid-burst with burst_cnt=1, fifo_full=1 for 3 cycles → fifo_wr_ena=0, req_ready[2]=0, grant held; after full clears, exactly 3 more beats, then rotate.
- Reset mid-burst: req0 owner at beat 2, pulse rst → no write in the reset cycle, grant=0; after reset, arbitration restarts from index 0.
- FIFO_ARB_TAG_EN: interleaved req1/req3 → fifo_tag equals 1 or 3, matching each written beat's source.
